// File: rtl/mem_port_arbiter_if.sv
// Bundle of signals between the instruction requester, the data requester,
// the arbiter and the shared single-port SRAM.
// slave  : the arbiter's view (takes requests, drives grants/responses/SRAM).
// master : the surrounding system's view (requesters plus SRAM read data).
interface mem_port_arbiter_if;
  // instruction side
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        i_flush;
  // data side
  logic        d_req;
  logic [3:0]  d_wen;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  // shared SRAM port
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  modport slave (
    input  i_req, i_addr, i_flush,
    input  d_req, d_wen, d_addr, d_wdata,
    input  sram_rdata,
    output i_gnt, i_rvalid, i_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output sram_en, sram_wen, sram_addr, sram_wdata
  );

  modport master (
    output i_req, i_addr, i_flush,
    output d_req, d_wen, d_addr, d_wdata,
    output sram_rdata,
    input  i_gnt, i_rvalid, i_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  sram_en, sram_wen, sram_addr, sram_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-cycle-latency SRAM port between an
// instruction fetch requester and a data load/store requester.
// Grants are combinational (same cycle as the request); read data returns
// one cycle later and is steered by a registered response-owner field.
// Data has priority over instruction fetch. Defining ARB_STARVE_GUARD_EN
// adds a starve counter that forces an instruction grant after
// STARVE_LIMIT consecutive denied cycles; without it priority is strict.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter logic [31:0] ADDR_MASK    = 32'h1FFFFFFF
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  // Owner of the response that is due in the current cycle.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INST  = 2'd1,
    OWN_DREAD = 2'd2
  } owner_t;

  owner_t owner_reg;
  logic   force_inst;
  logic   grant_i;
  logic   grant_d;
  logic   d_is_read;

  // Out-of-range starve limits are rejected at elaboration time.
  generate
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
      $error("mem_port_arbiter: STARVE_LIMIT must be in 1..15");
    end
  endgenerate

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0] starve_reg;

  // Once the fetch side has waited STARVE_MAX cycles it wins over data.
  assign force_inst = bus.i_req && (starve_reg == STARVE_MAX);

  // Count consecutive denied fetch cycles, saturating at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_reg <= '0;
    end else if (grant_i || !bus.i_req) begin
      starve_reg <= '0;
    end else if (starve_reg != STARVE_MAX) begin
      starve_reg <= starve_reg + 4'd1;
    end
  end
`else
  // Strict data priority: fetch waits as long as data keeps requesting.
  assign force_inst = 1'b0;
`endif

  // Grant selection; nothing is granted while reset is asserted.
  assign grant_d   = !reset && bus.d_req && !force_inst;
  assign grant_i   = !reset && bus.i_req && !grant_d;
  assign d_is_read = (bus.d_wen == 4'b0000);

  assign bus.i_gnt = grant_i;
  assign bus.d_gnt = grant_d;

  // Shared SRAM port: address from the winner, masked into SRAM space.
  assign bus.sram_en    = grant_i || grant_d;
  assign bus.sram_addr  = (grant_d ? bus.d_addr : bus.i_addr) & ADDR_MASK;
  assign bus.sram_wdata = bus.d_wdata;

  // Byte-lane write enables pass through only on a data grant.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_wen_lane
      assign bus.sram_wen[gi] = grant_d && bus.d_wen[gi];
    end
  endgenerate

  // Record who owns the response that returns next cycle. A fetch granted
  // while flush is high is already stale, so it is recorded as NONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_reg <= OWN_NONE;
    end else if (grant_i) begin
      owner_reg <= bus.i_flush ? OWN_NONE : OWN_INST;
    end else if (grant_d && d_is_read) begin
      owner_reg <= OWN_DREAD;
    end else begin
      owner_reg <= OWN_NONE;
    end
  end

  // Response steering; flush only kills the instruction-side response and
  // reset drops whatever response was in flight.
  assign bus.i_rvalid = !reset && (owner_reg == OWN_INST) && !bus.i_flush;
  assign bus.d_rvalid = !reset && (owner_reg == OWN_DREAD);
  assign bus.i_rdata  = bus.sram_rdata;
  assign bus.d_rdata  = bus.sram_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter. Directed stimulus pushes the
// expected grants and responses (tagged with their cycle) into per-event
// queues; a negedge monitor pops and compares whenever the DUT shows an
// event, and flags events that were expected but did not appear.
module tb_mem_port_arbiter;

  localparam logic [31:0] PAT = 32'hA5A50F0F;

  typedef struct {
    int          cyc;
    logic [31:0] v;
    logic [3:0]  wen;
    logic [31:0] wd;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;

  exp_t q_ig[$];
  exp_t q_dg[$];
  exp_t q_irv[$];
  exp_t q_drv[$];

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .STARVE_LIMIT(4),
    .ADDR_MASK   (32'h1FFFFFFF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cycle counter and SRAM model (read data one cycle after issue)
  initial begin
    cyc = 0;
    bus.sram_rdata = 32'hDEADBEEF;
    forever begin
      @(posedge clk);
      if (bus.sram_en && bus.sram_wen == 4'b0000) bus.sram_rdata = bus.sram_addr ^ PAT;
      else bus.sram_rdata = 32'hDEADBEEF;
      cyc++;
    end
  end

  task automatic fail_line(input string name, input logic [31:0] act, input logic [31:0] req);
    errors++;
    $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
  endtask

  task automatic push_ig(input int c, input logic [31:0] a);
    exp_t e;
    e.cyc = c; e.v = a; e.wen = 4'b0; e.wd = 32'h0;
    q_ig.push_back(e);
  endtask

  task automatic push_dg(input int c, input logic [31:0] a, input logic [3:0] w, input logic [31:0] wd);
    exp_t e;
    e.cyc = c; e.v = a; e.wen = w; e.wd = wd;
    q_dg.push_back(e);
  endtask

  task automatic push_irv(input int c, input logic [31:0] a);
    exp_t e;
    e.cyc = c; e.v = a ^ PAT; e.wen = 4'b0; e.wd = 32'h0;
    q_irv.push_back(e);
  endtask

  task automatic push_drv(input int c, input logic [31:0] a);
    exp_t e;
    e.cyc = c; e.v = a ^ PAT; e.wen = 4'b0; e.wd = 32'h0;
    q_drv.push_back(e);
  endtask

  // monitor / scoreboard
  initial begin
    exp_t e;
    checks = 0;
    errors = 0;
    forever begin
      @(negedge clk);
      checks++;
      if (bus.i_gnt && bus.d_gnt) fail_line("gnt_exclusive", {30'b0, bus.i_gnt, bus.d_gnt}, 32'h1);
      checks++;
      if (bus.sram_en !== (bus.i_gnt | bus.d_gnt) || (!bus.sram_en && bus.sram_wen !== 4'b0))
        fail_line("sram_en_wen", {27'b0, bus.sram_en, bus.sram_wen}, {31'b0, bus.i_gnt | bus.d_gnt});

      if (bus.i_gnt) begin
        checks++;
        if (q_ig.size() == 0) fail_line("i_gnt_unexpected", 32'h1, 32'h0);
        else begin
          e = q_ig.pop_front();
          if (e.cyc != cyc) fail_line("i_gnt_cycle", cyc, e.cyc);
          else if (bus.sram_addr !== e.v || bus.sram_wen !== 4'b0) fail_line("i_gnt_addr", bus.sram_addr, e.v);
          else $display("cyc=%0d i_gnt addr=%h ok", cyc, bus.sram_addr);
        end
      end else if (q_ig.size() != 0 && q_ig[0].cyc <= cyc) begin
        checks++;
        e = q_ig.pop_front();
        fail_line("i_gnt_missing", 32'h0, e.v);
      end

      if (bus.d_gnt) begin
        checks++;
        if (q_dg.size() == 0) fail_line("d_gnt_unexpected", 32'h1, 32'h0);
        else begin
          e = q_dg.pop_front();
          if (e.cyc != cyc) fail_line("d_gnt_cycle", cyc, e.cyc);
          else if (bus.sram_addr !== e.v) fail_line("d_gnt_addr", bus.sram_addr, e.v);
          else if (bus.sram_wen !== e.wen) fail_line("d_gnt_wen", {28'b0, bus.sram_wen}, {28'b0, e.wen});
          else if (bus.sram_wdata !== e.wd) fail_line("d_gnt_wdata", bus.sram_wdata, e.wd);
          else $display("cyc=%0d d_gnt addr=%h wen=%b ok", cyc, bus.sram_addr, bus.sram_wen);
        end
      end else if (q_dg.size() != 0 && q_dg[0].cyc <= cyc) begin
        checks++;
        e = q_dg.pop_front();
        fail_line("d_gnt_missing", 32'h0, e.v);
      end

      if (bus.i_rvalid) begin
        checks++;
        if (q_irv.size() == 0) fail_line("i_rvalid_unexpected", 32'h1, 32'h0);
        else begin
          e = q_irv.pop_front();
          if (e.cyc != cyc) fail_line("i_rvalid_cycle", cyc, e.cyc);
          else if (bus.i_rdata !== e.v) fail_line("i_rdata", bus.i_rdata, e.v);
          else $display("cyc=%0d i_rvalid data=%h ok", cyc, bus.i_rdata);
        end
      end else if (q_irv.size() != 0 && q_irv[0].cyc <= cyc) begin
        checks++;
        e = q_irv.pop_front();
        fail_line("i_rvalid_missing", 32'h0, e.v);
      end

      if (bus.d_rvalid) begin
        checks++;
        if (q_drv.size() == 0) fail_line("d_rvalid_unexpected", 32'h1, 32'h0);
        else begin
          e = q_drv.pop_front();
          if (e.cyc != cyc) fail_line("d_rvalid_cycle", cyc, e.cyc);
          else if (bus.d_rdata !== e.v) fail_line("d_rdata", bus.d_rdata, e.v);
          else $display("cyc=%0d d_rvalid data=%h ok", cyc, bus.d_rdata);
        end
      end else if (q_drv.size() != 0 && q_drv[0].cyc <= cyc) begin
        checks++;
        e = q_drv.pop_front();
        fail_line("d_rvalid_missing", 32'h0, e.v);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req = 1'b0; bus.i_addr = 32'h0; bus.i_flush = 1'b0;
    bus.d_req = 1'b0; bus.d_wen = 4'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
  endtask

  // directed stimulus
  initial begin
    logic [31:0] ba [4];
    logic [31:0] bm [4];
    ba[0] = 32'hBFC00200; bm[0] = 32'h1FC00200;
    ba[1] = 32'hBFC00204; bm[1] = 32'h1FC00204;
    ba[2] = 32'hFFFFFFFF; bm[2] = 32'h1FFFFFFF;
    ba[3] = 32'h00000008; bm[3] = 32'h00000008;

    // reset with both requesters active: no grant may appear
    idle_inputs();
    reset = 1'b1;
    bus.i_req = 1'b1; bus.i_addr = 32'hBFC00000;
    bus.d_req = 1'b1; bus.d_addr = 32'h80000000;
    tick(); tick(); tick();
    idle_inputs();
    reset = 1'b0;
    tick(); tick();

    // lone fetch
    bus.i_req = 1'b1; bus.i_addr = 32'hBFC00000;
    push_ig(cyc, 32'h1FC00000); push_irv(cyc + 1, 32'h1FC00000);
    tick();
    idle_inputs();
    tick();

    // simultaneous: data read wins, fetch the next cycle
    bus.i_req = 1'b1; bus.i_addr = 32'hBFC00010;
    bus.d_req = 1'b1; bus.d_wen = 4'b0; bus.d_addr = 32'h80001000;
    push_dg(cyc, 32'h00001000, 4'b0, 32'h0); push_drv(cyc + 1, 32'h00001000);
    tick();
    bus.d_req = 1'b0;
    push_ig(cyc, 32'h1FC00010); push_irv(cyc + 1, 32'h1FC00010);
    tick();
    idle_inputs();
    tick();

    // data write: no response
    bus.d_req = 1'b1; bus.d_wen = 4'b0011; bus.d_addr = 32'h80002004; bus.d_wdata = 32'h0000BEEF;
    push_dg(cyc, 32'h00002004, 4'b0011, 32'h0000BEEF);
    tick();
    idle_inputs();
    tick();

    // flush: suppresses outstanding fetch, new fetch under flush also dropped
    bus.i_req = 1'b1; bus.i_addr = 32'hBFC00020;
    push_ig(cyc, 32'h1FC00020);
    tick();
    bus.i_flush = 1'b1; bus.i_addr = 32'hBFC00024;
    push_ig(cyc, 32'h1FC00024);
    tick();
    bus.i_flush = 1'b0; bus.i_addr = 32'hBFC00028;
    push_ig(cyc, 32'h1FC00028); push_irv(cyc + 1, 32'h1FC00028);
    tick();
    idle_inputs();
    bus.d_req = 1'b1; bus.d_addr = 32'h80003000;
    push_dg(cyc, 32'h00003000, 4'b0, 32'h0); push_drv(cyc + 1, 32'h00003000);
    tick();
    idle_inputs();
    bus.i_flush = 1'b1;          // must not touch the data response
    tick();
    idle_inputs();
    tick();

    // starve guard / strict priority with both held high for 20 cycles
    bus.i_req = 1'b1; bus.i_addr = 32'hBFC00100;
    bus.d_req = 1'b1; bus.d_wen = 4'b0; bus.d_addr = 32'h80004000;
    for (int k = 0; k < 20; k++) begin
`ifdef ARB_STARVE_GUARD_EN
      if (k % 5 == 4) begin
        push_ig(cyc, 32'h1FC00100); push_irv(cyc + 1, 32'h1FC00100);
      end else begin
        push_dg(cyc, 32'h00004000, 4'b0, 32'h0); push_drv(cyc + 1, 32'h00004000);
      end
`else
      push_dg(cyc, 32'h00004000, 4'b0, 32'h0); push_drv(cyc + 1, 32'h00004000);
`endif
      tick();
    end
    idle_inputs();
    tick(); tick();

    // reset in the cycle after a data read grant drops the response
    bus.d_req = 1'b1; bus.d_addr = 32'h80005000;
    push_dg(cyc, 32'h00005000, 4'b0, 32'h0);
    tick();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick(); tick();

    // back-to-back fetches including mask boundary addresses
    for (int k = 0; k < 4; k++) begin
      bus.i_req = 1'b1; bus.i_addr = ba[k];
      push_ig(cyc, bm[k]); push_irv(cyc + 1, bm[k]);
      tick();
    end
    idle_inputs();

    // back-to-back data read / write / read
    bus.d_req = 1'b1; bus.d_wen = 4'b0; bus.d_addr = 32'h80006000;
    push_dg(cyc, 32'h00006000, 4'b0, 32'h0); push_drv(cyc + 1, 32'h00006000);
    tick();
    bus.d_wen = 4'b1111; bus.d_addr = 32'h80006004; bus.d_wdata = 32'h12345678;
    push_dg(cyc, 32'h00006004, 4'b1111, 32'h12345678);
    tick();
    bus.d_wen = 4'b0; bus.d_addr = 32'h80006008; bus.d_wdata = 32'h0;
    push_dg(cyc, 32'h00006008, 4'b0, 32'h0); push_drv(cyc + 1, 32'h00006008);
    tick();
    idle_inputs();
    tick(); tick(); tick();

    // every expected event must have been consumed
    checks++;
    if (q_ig.size() != 0) fail_line("i_gnt_leftover", q_ig.size(), 32'h0);
    checks++;
    if (q_dg.size() != 0) fail_line("d_gnt_leftover", q_dg.size(), 32'h0);
    checks++;
    if (q_irv.size() != 0) fail_line("i_rvalid_leftover", q_irv.size(), 32'h0);
    checks++;
    if (q_drv.size() != 0) fail_line("d_rvalid_leftover", q_drv.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL take parameter STARVE_LIMIT, default 4: the number of consecutive cycles the instruction requester may be denied before it gets forced priority (range 1..15).
REQ-002 SHALL take parameter ADDR_MASK, default 32'h1FFFFFFF: the mask ANDed onto every address driven to the SRAM.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port i_req, input, 1 bit: instruction fetch request, held until granted.
REQ-006 SHALL have port i_addr, input, 32 bits: instruction fetch address.
REQ-007 SHALL have port i_gnt, output, 1 bit: the instruction request is issued this cycle.
REQ-008 SHALL have port i_rvalid, output, 1 bit: i_rdata is valid this cycle.
REQ-009 SHALL have port i_rdata, output, 32 bits: instruction read data.
REQ-010 SHALL have port i_flush, input, 1 bit: discard any outstanding instruction response.
REQ-011 SHALL have port d_req, input, 1 bit: data request, held until granted.
REQ-012 SHALL have port d_wen, input, 4 bits: byte write enables; all-zero means a read.
REQ-013 SHALL have ports d_addr and d_wdata, inputs, 32 bits each: data address and write data.
REQ-014 SHALL have ports d_gnt, d_rvalid (outputs, 1 bit) and d_rdata (output, 32 bits), defined the same way as the instruction-side signals.
REQ-015 SHALL have ports sram_en (1 bit), sram_wen (4 bits), sram_addr (32 bits) and sram_wdata (32 bits), all outputs: the shared SRAM port.
REQ-016 SHALL have port sram_rdata, input, 32 bits: SRAM read data, valid one cycle after the access is issued.

Function
REQ-017 SHALL grant at most one requester per cycle; i_gnt and d_gnt are never high together.
REQ-018 SHALL grant d_req over i_req by default; a lone requester is always granted in the same cycle.
REQ-019 SHALL drive sram_en=1 in any granted cycle; sram_addr = granted address & ADDR_MASK; sram_wen = d_wen on a data grant, else 0; sram_wdata = d_wdata.
REQ-020 SHALL keep sram_en=0 and sram_wen=0 in cycles with no grant.
REQ-021 SHALL track the owner of the outstanding response in a registered field with values NONE, INST, DREAD.
- On an i_gnt: owner becomes INST.
- On a data read grant (d_wen==0): owner becomes DREAD.
- On a data write grant or no grant: owner becomes NONE.
REQ-022 SHALL assert i_rvalid (or d_rvalid) exactly one cycle after the corresponding grant, with i_rdata (or d_rdata) = sram_rdata; rdata is don't-care when rvalid is low.
REQ-023 SHALL produce no rvalid for a data write.
REQ-024 SHALL support back-to-back grants every cycle, so sustained throughput is one access per cycle.
REQ-025 SHALL, when i_flush is high and owner==INST, suppress i_rvalid in that cycle.
REQ-026 SHALL, when i_flush is high in a cycle with a new i_gnt, record that grant's owner as NONE; i_gnt itself is still asserted.
REQ-027 SHALL never let i_flush affect data-side signals.
REQ-028 SHALL keep a 4-bit starve counter.
- It increments when i_req is high and i_gnt is low, saturating at STARVE_LIMIT.
- It clears on i_gnt or when i_req is low.
REQ-029 SHALL, when starve==STARVE_LIMIT and i_req is high, grant the instruction requester even if d_req is high, then clear starve.

Reset
REQ-030 SHALL, while reset is high at a clock edge, set owner=NONE and starve=0.
REQ-031 SHALL, one cycle after a reset edge, hold i_gnt, d_gnt, i_rvalid, d_rvalid, sram_en and sram_wen at 0 until a request arrives.
REQ-032 SHALL drop any response outstanding when reset is applied; no rvalid follows it.
REQ-033 SHALL issue no grant in any cycle in which reset is high.

Configuration
REQ-034 SHALL, when macro ARB_STARVE_GUARD_EN is defined, include the starve counter and forced instruction priority (REQ-028, REQ-029).
REQ-035 SHALL, when ARB_STARVE_GUARD_EN is undefined, omit the counter and apply strict data priority: i_req waits as long as d_req stays high.

Verification
REQ-036 SHALL cover a lone fetch: i_req=1, i_addr=32'hBFC00000 -> i_gnt=1 and sram_addr=32'h1FC00000 in the same cycle; next cycle i_rvalid=1 and i_rdata=sram_rdata.
REQ-037 SHALL cover a simultaneous request: i_req=1 and d_req=1 (read, d_addr=32'h80001000) -> d_gnt=1, sram_addr=32'h00001000; the following cycle i_gnt=1 and d_rvalid=1.
REQ-038 SHALL cover a data write: d_wen=4'b0011, d_wdata=32'h0000BEEF -> sram_wen=4'b0011 on the grant cycle and no d_rvalid the next cycle.
REQ-039 SHALL cover a flush: i_gnt in cycle N and i_flush=1 in cycle N+1 -> i_rvalid=0 in cycle N+1, and a new i_gnt is allowed in cycle N+1.
REQ-040 SHALL cover the starve guard: with the macro defined and STARVE_LIMIT=4, d_req and i_req held high -> d_gnt for 4 cycles, i_gnt in cycle 5, d_gnt again in cycle 6; with the macro undefined, no i_gnt for 20 cycles.
REQ-041 SHALL cover reset mid-operation: reset=1 in the cycle after a data read grant -> d_rvalid=0, and all outputs are 0 the next cycle with inputs idle.
